// File: rtl/control_multicycle.sv
// rtl/control_multicycle.sv - multicycle MIPS main control FSM with memory timeout and illegal-opcode trap
// Optional JMP instruction (opcode 0x02) is built when CONTROL_JUMP_EN is defined.
module control_multicycle #(
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 8,
    parameter int TRAP_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic [1:0] branch,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal,
    output logic       fault,
    output logic       inst_done
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
`ifdef CONTROL_JUMP_EN
    localparam logic [5:0] OP_J     = 6'h02;
`endif

    // Timeout fires on the cycle the counter sits at MEM_TIMEOUT-1 without mem_ready.
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MADR,
        S_MRD,
        S_MWB,
        S_MWR,
        S_REX,
        S_RWB,
        S_BR,
        S_AEX,
        S_AWB,
        S_FAULT
`ifdef CONTROL_JUMP_EN
        , S_JMP
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       opcode_q;
    logic             mem_wait;
    logic             timed_out;
    logic             op_ok;

    function automatic logic op_known(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI: op_known = 1'b1;
`ifdef CONTROL_JUMP_EN
            OP_J:                                            op_known = 1'b1;
`endif
            default:                                         op_known = 1'b0;
        endcase
    endfunction

    assign op_ok     = op_known(opcode);
    assign mem_wait  = (state_q == S_FETCH) || (state_q == S_MRD) || (state_q == S_MWR);
    assign timed_out = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_q == TO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      state_d = S_DECODE;
                else if (timed_out) state_d = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:       state_d = S_REX;
                    OP_LW, OP_SW:   state_d = S_MADR;
                    OP_BEQ, OP_BNE: state_d = S_BR;
                    OP_ADDI:        state_d = S_AEX;
`ifdef CONTROL_JUMP_EN
                    OP_J:           state_d = S_JMP;
`endif
                    default:        state_d = (TRAP_ILLEGAL != 0) ? S_FAULT : S_FETCH;
                endcase
            end
            S_MADR:   state_d = (opcode_q == OP_LW) ? S_MRD : S_MWR;
            S_MRD: begin
                if (mem_ready)      state_d = S_MWB;
                else if (timed_out) state_d = S_FAULT;
            end
            S_MWB:    state_d = S_FETCH;
            S_MWR: begin
                if (mem_ready)      state_d = S_FETCH;
                else if (timed_out) state_d = S_FAULT;
            end
            S_REX:    state_d = S_RWB;
            S_RWB:    state_d = S_FETCH;
            S_BR:     state_d = S_FETCH;
            S_AEX:    state_d = S_AWB;
            S_AWB:    state_d = S_FETCH;
`ifdef CONTROL_JUMP_EN
            S_JMP:    state_d = S_FETCH;
`endif
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (mem_wait && !mem_ready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        branch     = 2'b00;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        fault      = 1'b0;
        inst_done  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                if (!op_ok) begin
                    illegal   = 1'b1;
                    inst_done = (TRAP_ILLEGAL == 0);
                end
            end
            S_MADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                inst_done  = 1'b1;
            end
            S_MWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                inst_done = mem_ready;
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_RWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                inst_done = 1'b1;
            end
            S_BR: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_src    = 2'b01;
                branch    = {opcode_q == OP_BNE, opcode_q == OP_BEQ};
                inst_done = 1'b1;
            end
            S_AEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_AWB: begin
                reg_write = 1'b1;
                inst_done = 1'b1;
            end
`ifdef CONTROL_JUMP_EN
            S_JMP: begin
                pc_src    = 2'b10;
                pc_write  = 1'b1;
                inst_done = 1'b1;
            end
`endif
            S_FAULT:  fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_multicycle.sv
// tb/tb_control_multicycle.sv - bench for control_multicycle: directed literals plus random stimulus vs instruction-plan model
module tb_control_multicycle;

    localparam int TO_A   = 4;
    localparam int TO_B   = 0;
    localparam bit TRAP_A = 1'b1;
    localparam bit TRAP_B = 1'b0;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal;
        logic       fault;
        logic       inst_done;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b1;

    logic       pc_write_a, iord_a, mem_read_a, mem_write_a, ir_write_a, mem_to_reg_a;
    logic       reg_dst_a, reg_write_a, alu_src_a_a, illegal_a, fault_a, inst_done_a;
    logic [1:0] branch_a, alu_src_b_a, alu_op_a, pc_src_a;
    logic       pc_write_b, iord_b, mem_read_b, mem_write_b, ir_write_b, mem_to_reg_b;
    logic       reg_dst_b, reg_write_b, alu_src_a_b, illegal_b, fault_b, inst_done_b;
    logic [1:0] branch_b, alu_src_b_b, alu_op_b, pc_src_b;

    outs_t oa, ob;
    assign oa = {pc_write_a, branch_a, iord_a, mem_read_a, mem_write_a, ir_write_a, mem_to_reg_a,
                 reg_dst_a, reg_write_a, alu_src_a_a, alu_src_b_a, alu_op_a, pc_src_a,
                 illegal_a, fault_a, inst_done_a};
    assign ob = {pc_write_b, branch_b, iord_b, mem_read_b, mem_write_b, ir_write_b, mem_to_reg_b,
                 reg_dst_b, reg_write_b, alu_src_a_b, alu_src_b_b, alu_op_b, pc_src_b,
                 illegal_b, fault_b, inst_done_b};

    control_multicycle #(.MEM_TIMEOUT(TO_A), .CNT_W(8), .TRAP_ILLEGAL(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write_a), .branch(branch_a), .iord(iord_a), .mem_read(mem_read_a),
        .mem_write(mem_write_a), .ir_write(ir_write_a), .mem_to_reg(mem_to_reg_a),
        .reg_dst(reg_dst_a), .reg_write(reg_write_a), .alu_src_a(alu_src_a_a),
        .alu_src_b(alu_src_b_a), .alu_op(alu_op_a), .pc_src(pc_src_a),
        .illegal(illegal_a), .fault(fault_a), .inst_done(inst_done_a)
    );

    control_multicycle #(.MEM_TIMEOUT(TO_B), .CNT_W(8), .TRAP_ILLEGAL(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write_b), .branch(branch_b), .iord(iord_b), .mem_read(mem_read_b),
        .mem_write(mem_write_b), .ir_write(ir_write_b), .mem_to_reg(mem_to_reg_b),
        .reg_dst(reg_dst_b), .reg_write(reg_write_b), .alu_src_a(alu_src_a_b),
        .alu_src_b(alu_src_b_b), .alu_op(alu_op_b), .pc_src(pc_src_b),
        .illegal(illegal_b), .fault(fault_b), .inst_done(inst_done_b)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Model: each instance holds the step it is in plus the remaining steps of the current instruction.
    string      cur [2] = '{"IDLE", "IDLE"};
    string      plan[2][3];
    int         np  [2] = '{0, 0};
    int         cnt [2] = '{0, 0};
    logic [5:0] opq [2] = '{6'h00, 6'h00};

    function automatic bit known(input logic [5:0] op);
        bit k;
        k = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05) || (op == 6'h08);
`ifdef CONTROL_JUMP_EN
        k = k || (op == 6'h02);
`endif
        return k;
    endfunction

    task automatic push(input int i, input string s);
        plan[i][np[i]] = s;
        np[i]++;
    endtask

    task automatic model_step(input int i);
        int to;
        bit tr;
        to = (i == 0) ? TO_A : TO_B;
        tr = (i == 0) ? TRAP_A : TRAP_B;
        if (rst_n !== 1'b1) begin
            cur[i] = "IDLE"; np[i] = 0; cnt[i] = 0; opq[i] = 6'h00;
            return;
        end
        if (cur[i] == "FAULT") return;
        if ((cur[i] == "FETCH" || cur[i] == "MRD" || cur[i] == "MWR") && !mem_ready) begin
            if (to != 0 && cnt[i] == to - 1) begin
                cur[i] = "FAULT"; np[i] = 0; cnt[i] = 0;
            end else begin
                cnt[i]++;
            end
            return;
        end
        if (cur[i] == "FETCH") push(i, "DECODE");
        else if (cur[i] == "DECODE") begin
            opq[i] = opcode;
            if (!known(opcode)) begin
                if (tr) push(i, "FAULT");
            end else if (opcode == 6'h00) begin push(i, "REX"); push(i, "RWB"); end
            else if (opcode == 6'h23) begin push(i, "MADR"); push(i, "MRD"); push(i, "MWB"); end
            else if (opcode == 6'h2B) begin push(i, "MADR"); push(i, "MWR"); end
            else if (opcode == 6'h04 || opcode == 6'h05) push(i, "BR");
            else if (opcode == 6'h08) begin push(i, "AEX"); push(i, "AWB"); end
            else push(i, "JMP");
        end
        if (np[i] > 0) begin
            cur[i] = plan[i][0];
            for (int k = 0; k < 2; k++) plan[i][k] = plan[i][k+1];
            np[i]--;
        end else begin
            cur[i] = "FETCH";
        end
        cnt[i] = 0;
    endtask

    function automatic outs_t exp_out(input int i);
        outs_t o;
        bit    tr;
        o  = '0;
        tr = (i == 0) ? TRAP_A : TRAP_B;
        if (rst_n !== 1'b1) return o;
        case (cur[i])
            "FETCH":  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.ir_write = mem_ready; o.pc_write = mem_ready; end
            "DECODE": begin
                o.alu_src_b = 2'b11;
                if (!known(opcode)) begin o.illegal = 1; o.inst_done = !tr; end
            end
            "MADR":   begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            "MRD":    begin o.mem_read = 1; o.iord = 1; end
            "MWB":    begin o.mem_to_reg = 1; o.reg_write = 1; o.inst_done = 1; end
            "MWR":    begin o.mem_write = 1; o.iord = 1; o.inst_done = mem_ready; end
            "REX":    begin o.alu_src_a = 1; o.alu_op = 2'b10; end
            "RWB":    begin o.reg_dst = 1; o.reg_write = 1; o.inst_done = 1; end
            "BR":     begin
                o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.inst_done = 1;
                o.branch = {opq[i] == 6'h05, opq[i] == 6'h04};
            end
            "AEX":    begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
            "AWB":    begin o.reg_write = 1; o.inst_done = 1; end
            "JMP":    begin o.pc_src = 2'b10; o.pc_write = 1; o.inst_done = 1; end
            "FAULT":  o.fault = 1;
            default: ;
        endcase
        return o;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step(0);
        model_step(1);
    end

    initial forever begin
        @(negedge clk);
        chk($sformatf("model_a[%s]", cur[0]), 32'(oa), 32'(exp_out(0)));
        chk($sformatf("model_b[%s]", cur[1]), 32'(ob), 32'(exp_out(1)));
    end

    task automatic step(input logic rdy, input logic [5:0] op);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        opcode    = op;
        @(negedge clk);
    endtask

    logic [5:0] ops [8] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h02, 6'h3F};

    initial begin
        int fault_cycles;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_zero_a", 32'(oa), 32'h0);
        chk("reset_zero_b", 32'(ob), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_zero", 32'(oa), 32'h0);

        step(1, 6'h00);
        chk("fetch_rd_ir_pc", {mem_read_a, ir_write_a, pc_write_a, alu_src_b_a}, 5'b11101);
        step(1, 6'h00);
        chk("decode_srcb", alu_src_b_a, 2'b11);
        step(1, 6'h00);
        chk("rex_aluop", {alu_src_a_a, alu_op_a}, 3'b110);
        step(1, 6'h23);
        chk("rwb_write", {reg_dst_a, reg_write_a, inst_done_a}, 3'b111);

        step(1, 6'h23);
        step(1, 6'h23);
        step(1, 6'h23);
        for (int k = 0; k < 4; k++) begin
            step(k == 3, 6'h23);
            chk($sformatf("mrd_hold%0d", k), {mem_read_a, iord_a, fault_a}, 3'b110);
        end
        step(1, 6'h05);
        chk("mwb_write", {mem_to_reg_a, reg_write_a, reg_dst_a, fault_a}, 4'b1100);

        step(1, 6'h05);
        step(1, 6'h05);
        step(1, 6'h04);
        chk("bne_br", {branch_a, alu_op_a, pc_src_a}, 6'b100101);
        step(1, 6'h04);
        step(1, 6'h04);
        step(1, 6'h2B);
        chk("beq_br", branch_a, 2'b01);

        step(1, 6'h2B);
        step(1, 6'h2B);
        step(1, 6'h2B);
        for (int k = 0; k < 4; k++) begin
            step(0, 6'h2B);
            chk($sformatf("mwr_wait%0d", k), {mem_write_a, fault_a}, 2'b10);
        end
        step(0, 6'h2B);
        chk("timeout_fault", {fault_a, mem_write_a}, 2'b10);
        step(1, 6'h2B);
        chk("fault_sticky", {fault_a, mem_write_b}, 2'b11);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_mid_mwr", {mem_write_b, iord_b, fault_a}, 3'b000);
        @(posedge clk);
        #1 rst_n = 1'b1;

        step(1, 6'h3F);
        step(1, 6'h3F);
        chk("illegal_pulse", {illegal_a, inst_done_a, illegal_b, inst_done_b}, 4'b1011);
        step(1, 6'h02);
        chk("illegal_next", {fault_a, mem_read_b, illegal_a, illegal_b}, 4'b1100);
        step(1, 6'h02);
`ifdef CONTROL_JUMP_EN
        chk("jmp_decode", illegal_b, 1'b0);
        step(1, 6'h02);
        chk("jmp_state", {pc_src_b, pc_write_b, inst_done_b}, 4'b1011);
`else
        chk("j_illegal", {illegal_b, inst_done_b}, 2'b11);
`endif

        @(posedge clk);
        #1 rst_n = 1'b0;
        fault_cycles = 0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rst_n = 1'b1;
            end else begin
                if (cur[0] == "FAULT") fault_cycles++;
                if (fault_cycles > 2 || $urandom_range(0, 399) == 0) begin
                    rst_n = 1'b0;
                    fault_cycles = 0;
                end
            end
            mem_ready = ($urandom_range(0, 99) < 65);
            opcode    = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) opcode = 6'($urandom);
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
